controle_inimigo: RTL and testbench

//  Movement/life-cycle controller for one enemy sprite. Paces the enemy across the 640x480 field:

---
 rtl/controle_inimigo_pkg.sv | 27 ++
 rtl/controle_inimigo_divisor_tick.sv | 35 +++
 rtl/controle_inimigo.sv | 133 +++++++++++++
 tb/tb_controle_inimigo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/controle_inimigo_pkg.sv
// ============================================================================
// Module : controle_inimigo_pkg
// Brief  : Shared FSM encodings and screen constants for sprite controllers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package controle_inimigo_pkg;

    typedef enum logic [2:0] {
        ST_DIR   = 3'd0,
        ST_ESQ   = 3'd1,
        ST_DESCE = 3'd2,
        ST_MORTO = 3'd3,
        ST_FIM   = 3'd4
    } estado_t;

    localparam int c_TELA_L = 640;
    localparam int c_TELA_A = 480;

    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/controle_inimigo_divisor_tick.sv
// ============================================================================
// Module : divisor_tick
// Brief  : Free-running prescaler; tick is high while the count sits at DIV-1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module divisor_tick #(
    parameter int DIV = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int             c_W   = $clog2(DIV);
    localparam logic [c_W-1:0] c_ULT = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;

    // Holding en low freezes the count in place rather than clearing it.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_ULT) ? '0 : r_cnt + c_W'(1);
        end
    end

    assign tick = (r_cnt == c_ULT);

endmodule

`default_nettype wire

// File: rtl/controle_inimigo.sv
// ============================================================================
// Module : controle_inimigo
// Brief  : Enemy sprite sweep/descent/death controller over the 640x480 field.
// Rev    : 1.0
// ============================================================================
`default_nettype none

import controle_inimigo_pkg::*;

module controle_inimigo #(
    parameter int TICK_DIV    = 500000,
    parameter int X_INI       = 300,
    parameter int Y_INI       = 300,
    parameter int LARGURA     = 11,
    parameter int ALTURA      = 8,
    parameter int PASSO_X     = 2,
    parameter int PASSO_Y     = 8,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = c_TELA_L - LARGURA,
    parameter int Y_MAX       = c_TELA_A - ALTURA,
    parameter int MORTO_TICKS = 100
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic       atingido,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [9:0] largura,
    output logic [9:0] altura,
    output logic       vivo,
    output logic       chegou_fundo
);

    localparam int              c_WM       = $clog2(MORTO_TICKS + 1);
    localparam logic [c_WM-1:0] c_MORTO_UL = c_WM'(MORTO_TICKS - 1);

    estado_t         r_estado;
    logic            r_ultima_dir;
    logic [c_WM-1:0] r_morto_cnt;

    logic        w_tick;
    logic        w_div_rst;
    logic        w_div_en;
    logic [10:0] w_x_dir;
    logic [10:0] w_y_desce;

    // Restart clears the prescaler too so cadence restarts from zero.
    assign w_div_rst = reset & ~reiniciarJogo;
    assign w_div_en  = ~pausa;

    divisor_tick #(
        .DIV (TICK_DIV)
    ) u_divisor_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (w_div_rst),
        .en       (w_div_en),
        .tick     (w_tick)
    );

    // 11-bit sums so that the wall/floor comparisons can never wrap.
    assign w_x_dir   = ext11(x) + 11'(PASSO_X);
    assign w_y_desce = ext11(y) + 11'(PASSO_Y);

    always_ff @(posedge CLOCK_50) begin
        if (!reset || reiniciarJogo) begin
            x            <= 10'(X_INI);
            y            <= 10'(Y_INI);
            largura      <= 10'(LARGURA);
            altura       <= 10'(ALTURA);
            vivo         <= 1'b1;
            chegou_fundo <= 1'b0;
            r_estado     <= ST_DIR;
            r_ultima_dir <= 1'b0;
            r_morto_cnt  <= '0;
        end else if (!pausa) begin
            if (atingido && (r_estado == ST_DIR || r_estado == ST_ESQ || r_estado == ST_DESCE)) begin
                vivo        <= 1'b0;
                r_morto_cnt <= '0;
                r_estado    <= ST_MORTO;
            end else if (w_tick) begin
                case (r_estado)
                    ST_DIR: begin
                        if (w_x_dir > 11'(X_MAX)) begin
                            x            <= 10'(X_MAX);
                            r_ultima_dir <= 1'b0;
                            r_estado     <= ST_DESCE;
                        end else begin
                            x <= w_x_dir[9:0];
                        end
                    end
                    ST_ESQ: begin
                        if (ext11(x) < 11'(X_MIN + PASSO_X)) begin
                            x            <= 10'(X_MIN);
                            r_ultima_dir <= 1'b1;
                            r_estado     <= ST_DESCE;
                        end else begin
                            x <= x - 10'(PASSO_X);
                        end
                    end
                    ST_DESCE: begin
                        if (w_y_desce >= 11'(Y_MAX)) begin
                            y            <= 10'(Y_MAX);
                            chegou_fundo <= 1'b1;
                            r_estado     <= ST_FIM;
                        end else begin
                            y        <= w_y_desce[9:0];
                            r_estado <= r_ultima_dir ? ST_DIR : ST_ESQ;
                        end
                    end
                    ST_MORTO: begin
                        if (r_morto_cnt == c_MORTO_UL) begin
                            x           <= 10'(X_INI);
                            y           <= 10'(Y_INI);
                            vivo        <= 1'b1;
                            r_morto_cnt <= '0;
                            r_estado    <= ST_DIR;
                        end else begin
                            r_morto_cnt <= r_morto_cnt + c_WM'(1);
                        end
                    end
                    default: begin
                        r_estado <= ST_FIM;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_controle_inimigo.sv
// ============================================================================
// Module : tb_controle_inimigo
// Brief  : Three enemy instances (centre, near right wall, near floor) against
//          a coordinate-level movement model plus pinned literal checkpoints.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_controle_inimigo;

    localparam int TICK_DIV    = 4;
    localparam int MORTO_TICKS = 3;
    localparam int PASSO_X     = 2;
    localparam int PASSO_Y     = 8;
    localparam int XMAX        = 629;
    localparam int YMAX        = 472;
    localparam int NDUT        = 3;

    int xi [NDUT];
    int yi [NDUT];

    logic CLOCK_50 = 1'b0;
    logic reset, pausa, reiniciarJogo, atingido;

    logic [9:0] x_o    [NDUT];
    logic [9:0] y_o    [NDUT];
    logic [9:0] larg_o [NDUT];
    logic [9:0] alt_o  [NDUT];
    logic       vivo_o [NDUT];
    logic       fundo_o[NDUT];

    int nvec = 0;
    int nerr = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    controle_inimigo #(.TICK_DIV(TICK_DIV), .X_INI(300), .Y_INI(300), .MORTO_TICKS(MORTO_TICKS)) u_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
        .atingido(atingido), .x(x_o[0]), .y(y_o[0]), .largura(larg_o[0]), .altura(alt_o[0]),
        .vivo(vivo_o[0]), .chegou_fundo(fundo_o[0]));

    controle_inimigo #(.TICK_DIV(TICK_DIV), .X_INI(626), .Y_INI(300), .MORTO_TICKS(MORTO_TICKS)) u_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
        .atingido(atingido), .x(x_o[1]), .y(y_o[1]), .largura(larg_o[1]), .altura(alt_o[1]),
        .vivo(vivo_o[1]), .chegou_fundo(fundo_o[1]));

    controle_inimigo #(.TICK_DIV(TICK_DIV), .X_INI(629), .Y_INI(464), .MORTO_TICKS(MORTO_TICKS)) u_c (
        .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
        .atingido(atingido), .x(x_o[2]), .y(y_o[2]), .largura(larg_o[2]), .altura(alt_o[2]),
        .vivo(vivo_o[2]), .chegou_fundo(fundo_o[2]));

    // Model: position in plain integers, direction as +1/-1, descent as a pending flag.
    int mx[NDUT], my[NDUT], mdir[NDUT], mdead[NDUT];
    bit malive[NDUT], mbottom[NDUT], mdesc[NDUT];
    int fase = 0;
    bit ativo = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic spawn(input int i);
        mx[i] = xi[i]; my[i] = yi[i]; mdir[i] = 1; mdead[i] = 0;
        malive[i] = 1'b1; mbottom[i] = 1'b0; mdesc[i] = 1'b0;
    endtask

    task automatic step(input int i, input bit tk);
        int nx;
        if (mbottom[i]) begin
            // game over: nothing moves
        end else if (!malive[i]) begin
            if (tk) begin
                mdead[i]++;
                if (mdead[i] == MORTO_TICKS) spawn(i);
            end
        end else if (atingido) begin
            malive[i] = 1'b0;
            mdead[i]  = 0;
        end else if (tk) begin
            if (mdesc[i]) begin
                if (my[i] + PASSO_Y >= YMAX) begin
                    my[i] = YMAX; mbottom[i] = 1'b1;
                end else begin
                    my[i] += PASSO_Y; mdir[i] = -mdir[i]; mdesc[i] = 1'b0;
                end
            end else begin
                nx = mx[i] + mdir[i] * PASSO_X;
                if (nx > XMAX)   begin mx[i] = XMAX; mdesc[i] = 1'b1; end
                else if (nx < 0) begin mx[i] = 0;    mdesc[i] = 1'b1; end
                else mx[i] = nx;
            end
        end
    endtask

    always @(posedge CLOCK_50) begin
        bit tk;
        tk = (fase == TICK_DIV - 1);
        if (!reset || reiniciarJogo) begin
            fase = 0;
            for (int i = 0; i < NDUT; i++) spawn(i);
            ativo = 1'b1;
        end else if (!pausa) begin
            fase = (fase + 1) % TICK_DIV;
            for (int i = 0; i < NDUT; i++) step(i, tk);
        end
        #1;
        if (ativo) begin
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("model_dut%0d", i),
                    64'({x_o[i], y_o[i], larg_o[i], alt_o[i], vivo_o[i], fundo_o[i]}),
                    64'({10'(mx[i]), 10'(my[i]), 10'd11, 10'd8, malive[i], mbottom[i]}));
            end
        end
    end

    initial begin
        xi[0] = 300; yi[0] = 300;
        xi[1] = 626; yi[1] = 300;
        xi[2] = 629; yi[2] = 464;
        reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0; atingido = 1'b0;

        @(negedge CLOCK_50); reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        chk("rst_x",     64'(x_o[0]),    64'd300);
        chk("rst_y",     64'(y_o[0]),    64'd300);
        chk("rst_larg",  64'(larg_o[0]), 64'd11);
        chk("rst_alt",   64'(alt_o[0]),  64'd8);
        chk("rst_vivo",  64'(vivo_o[0]), 64'd1);
        chk("rst_fundo", 64'(fundo_o[0]),64'd0);

        repeat (16) @(negedge CLOCK_50);
        chk("a_x_4ticks",   64'(x_o[0]),    64'd308);
        chk("b_x_wall",     64'(x_o[1]),    64'd627);
        chk("b_y_wall",     64'(y_o[1]),    64'd308);
        chk("c_y_floor",    64'(y_o[2]),    64'd472);
        chk("c_fundo",      64'(fundo_o[2]),64'd1);

        repeat (24) @(negedge CLOCK_50);
        chk("a_x_10ticks",  64'(x_o[0]),    64'd320);
        chk("c_y_frozen",   64'(y_o[2]),    64'd472);

        repeat (2) @(negedge CLOCK_50);
        pausa = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        pausa = 1'b0;
        chk("pause_hold",   64'(x_o[0]),    64'd320);
        @(negedge CLOCK_50);
        chk("pause_rem1",   64'(x_o[0]),    64'd320);
        @(negedge CLOCK_50);
        chk("pause_rem2",   64'(x_o[0]),    64'd322);

        atingido = 1'b1; @(negedge CLOCK_50); atingido = 1'b0;
        chk("hit_vivo",     64'(vivo_o[0]), 64'd0);
        chk("hit_xhold",    64'(x_o[0]),    64'd322);
        atingido = 1'b1; @(negedge CLOCK_50); atingido = 1'b0;
        repeat (9) @(negedge CLOCK_50);
        chk("dead_still",   64'(vivo_o[0]), 64'd0);
        @(negedge CLOCK_50);
        chk("respawn_vivo", 64'(vivo_o[0]), 64'd1);
        chk("respawn_x",    64'(x_o[0]),    64'd300);
        chk("respawn_y",    64'(y_o[0]),    64'd300);

        pausa = 1'b1; reiniciarJogo = 1'b1;
        @(negedge CLOCK_50);
        pausa = 1'b0; reiniciarJogo = 1'b0;
        chk("restart_c_y",     64'(y_o[2]),    64'd464);
        chk("restart_c_x",     64'(x_o[2]),    64'd629);
        chk("restart_c_fundo", 64'(fundo_o[2]),64'd0);
        repeat (8) @(negedge CLOCK_50);
        chk("c_floor_again",   64'(y_o[2]),    64'd472);

        atingido = 1'b1; @(negedge CLOCK_50); atingido = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0; @(negedge CLOCK_50); reset = 1'b1;
        chk("rst_mid_dead_vivo", 64'(vivo_o[0]), 64'd1);
        chk("rst_mid_dead_x",    64'(x_o[0]),    64'd300);
        chk("rst_fim_c_fundo",   64'(fundo_o[2]),64'd0);
        repeat (30) @(negedge CLOCK_50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
